spike_scheduler: RTL and testbench

// - Per-core axon scheduler. Sits directly downstream of each ring router and consumes its 34-bit send_scheduler packet.
// - Buffers each incoming spike in a circular bank of NUM_SLOTS tick slots, indexed by delivery delay.
// - On every global tick, emits the NUM_AXONS-bit axon vector for the current slot to the neuron array, then clears that slot.

---
 rtl/spike_scheduler.sv | 136 +++++++++++++
 tb/tb_spike_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/spike_scheduler.sv
// Per-core axon scheduler: buffers router spikes into delay-indexed tick slots
// and delivers one slot's axon vector per global tick.
module spike_scheduler #(
    parameter int unsigned NUM_AXONS = 256,
    parameter int unsigned NUM_SLOTS = 16,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           core_id,
    input  logic [33:0]          packet_in,
    input  logic                 tick,
    output logic [NUM_AXONS-1:0] axon_vec,
    output logic                 axon_vec_valid,
    output logic [CNT_W-1:0]     drop_count,
    output logic                 busy
);

    localparam int unsigned AXON_W = (NUM_AXONS > 1) ? $clog2(NUM_AXONS) : 1;
    localparam int unsigned SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam logic [3:0]  D_MAX  = 4'(NUM_SLOTS - 1);

    logic [NUM_AXONS-1:0] slots     [NUM_SLOTS];
    logic [NUM_AXONS-1:0] slots_nxt [NUM_SLOTS];
    logic [SLOT_W-1:0]    rd_ptr;

    logic                 pkt_valid;
    logic [1:0]           pkt_dest;
    logic [3:0]           pkt_delay;
    logic [7:0]           pkt_axon;
    logic                 axon_ok;
    logic                 accept;
    logic                 drop;
    logic [3:0]           d_eff;
    logic [SLOT_W-1:0]    target;
    logic [NUM_AXONS-1:0] spike_mask;
    logic [NUM_AXONS-1:0] deliver_vec;
    logic                 busy_nxt;
    logic                 unused_bits;

    // Packet field decode; reserved bits are deliberately ignored.
    assign pkt_valid   = packet_in[33];
    assign pkt_dest    = packet_in[32:31];
    assign pkt_delay   = packet_in[30:27];
    assign pkt_axon    = packet_in[7:0];
    assign unused_bits = &{1'b0, packet_in[26:8], pkt_axon};

    // Axon range check only exists when the core has fewer axons than the field can name.
    generate
        if (NUM_AXONS >= 256) begin : g_axon_full
            assign axon_ok = 1'b1;
        end else begin : g_axon_limited
            assign axon_ok = (pkt_axon < 8'(NUM_AXONS));
        end
    endgenerate

    assign accept = pkt_valid && (pkt_dest == core_id) && axon_ok;
    assign drop   = pkt_valid && !accept;

    // Effective delay: zero means next tick; large delays clamp to the ring depth.
    generate
        if (NUM_SLOTS < 16) begin : g_delay_clamp
            always_comb begin
                d_eff = (pkt_delay == 4'd0) ? 4'd1 : pkt_delay;
                if (d_eff > D_MAX) begin
                    d_eff = D_MAX;
                end
            end
        end else begin : g_delay_plain
            always_comb begin
                d_eff = (pkt_delay == 4'd0) ? 4'd1 : pkt_delay;
            end
        end
    endgenerate

    assign target = rd_ptr + SLOT_W'(d_eff - 4'd1);

    // One-hot mask of the incoming spike, zero when the packet is not accepted.
    always_comb begin
        spike_mask = '0;
        if (accept) begin
            spike_mask[pkt_axon[AXON_W-1:0]] = 1'b1;
        end
    end

    // Tick delivery includes a same-cycle spike aimed at the slot being read.
    always_comb begin
        deliver_vec = slots[rd_ptr];
        if (target == rd_ptr) begin
            deliver_vec = deliver_vec | spike_mask;
        end
    end

    // Next slot contents: set first, then clear the delivered slot so a bypassed spike is not kept.
    always_comb begin
        slots_nxt = slots;
        slots_nxt[target] = slots_nxt[target] | spike_mask;
        if (tick) begin
            slots_nxt[rd_ptr] = '0;
        end
    end

    // Busy reflects the slot bank after this cycle's updates.
    always_comb begin
        busy_nxt = 1'b0;
        for (int s = 0; s < int'(NUM_SLOTS); s++) begin
            busy_nxt = busy_nxt | (|slots_nxt[s]);
        end
    end

    // All state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < int'(NUM_SLOTS); s++) begin
                slots[s] <= '0;
            end
            rd_ptr         <= '0;
            axon_vec       <= '0;
            axon_vec_valid <= 1'b0;
            drop_count     <= '0;
            busy           <= 1'b0;
        end else begin
            slots          <= slots_nxt;
            axon_vec_valid <= tick;
            busy           <= busy_nxt;
            if (tick) begin
                rd_ptr   <= rd_ptr + SLOT_W'(1);
                axon_vec <= deliver_vec;
            end
            if (drop && (drop_count != '1)) begin
                drop_count <= drop_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_spike_scheduler.sv
// Bench for spike_scheduler: two instances (full-size and a small one with
// a narrow counter and a short ring) against a behavioural slot model.
module tb_spike_scheduler;

    localparam int unsigned NA0 = 256;
    localparam int unsigned NS0 = 16;
    localparam int unsigned CW0 = 16;
    localparam int unsigned NA1 = 128;
    localparam int unsigned NS1 = 8;
    localparam int unsigned CW1 = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          tick;
    logic [1:0]    core_id;
    logic [33:0]   pkt;

    logic [NA0-1:0] vec0;
    logic           vv0;
    logic [CW0-1:0] dc0;
    logic           busy0;
    logic [NA1-1:0] vec1;
    logic           vv1;
    logic [CW1-1:0] dc1;
    logic           busy1;

    int checks = 0;
    int errors = 0;

    // Behavioural model state, one entry per instance.
    logic [255:0] mslot [2][16];
    int unsigned  mptr  [2];
    int unsigned  mcnt  [2];
    logic [255:0] evec  [2];
    logic         evv   [2];
    logic         ebusy [2];

    always #5 clk = ~clk;

    spike_scheduler #(.NUM_AXONS(NA0), .NUM_SLOTS(NS0), .CNT_W(CW0)) dut0 (
        .clk(clk), .rst(rst), .core_id(core_id), .packet_in(pkt), .tick(tick),
        .axon_vec(vec0), .axon_vec_valid(vv0), .drop_count(dc0), .busy(busy0)
    );

    spike_scheduler #(.NUM_AXONS(NA1), .NUM_SLOTS(NS1), .CNT_W(CW1)) dut1 (
        .clk(clk), .rst(rst), .core_id(core_id), .packet_in(pkt), .tick(tick),
        .axon_vec(vec1), .axon_vec_valid(vv1), .drop_count(dc1), .busy(busy1)
    );

    function automatic logic [33:0] mk(input logic v, input logic [1:0] dest,
                                       input logic [3:0] d, input logic [7:0] ax);
        logic [18:0] junk;
        junk = 19'($urandom);
        return {v, dest, d, junk, ax};
    endfunction

    function automatic logic [255:0] bit_at(input int unsigned n);
        logic [255:0] m;
        m = '0;
        m[n] = 1'b1;
        return m;
    endfunction

    // Apply one cycle of inputs to the spec-level model; results are the expected post-edge outputs.
    task automatic model_cycle(input logic r, input logic t, input logic [33:0] p);
        for (int k = 0; k < 2; k++) begin
            int unsigned ns, na, cmax, d, tgt, ax;
            logic acc;
            logic [255:0] hit;
            ns   = (k == 0) ? NS0 : NS1;
            na   = (k == 0) ? NA0 : NA1;
            cmax = (k == 0) ? ((32'd1 << CW0) - 1) : ((32'd1 << CW1) - 1);
            if (r) begin
                for (int s = 0; s < 16; s++) mslot[k][s] = '0;
                mptr[k]  = 0;
                mcnt[k]  = 0;
                evec[k]  = '0;
                evv[k]   = 1'b0;
                ebusy[k] = 1'b0;
            end else begin
                ax  = p[7:0];
                d   = p[30:27];
                acc = p[33] && (p[32:31] == core_id) && (ax < na);
                if (p[33] && !acc && mcnt[k] < cmax) mcnt[k]++;
                if (d == 0) d = 1;
                if (d > ns - 1) d = ns - 1;
                tgt = (mptr[k] + d - 1) % ns;
                hit = '0;
                if (acc) hit[ax] = 1'b1;
                evv[k] = t;
                if (t) begin
                    evec[k] = mslot[k][mptr[k]];
                    if (tgt == mptr[k]) evec[k] = evec[k] | hit;
                    mslot[k][mptr[k]] = '0;
                    if (tgt != mptr[k]) mslot[k][tgt] = mslot[k][tgt] | hit;
                    mptr[k] = (mptr[k] + 1) % ns;
                end else begin
                    mslot[k][tgt] = mslot[k][tgt] | hit;
                end
                ebusy[k] = 1'b0;
                for (int s = 0; s < int'(ns); s++)
                    if (mslot[k][s] != '0) ebusy[k] = 1'b1;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] req);
        checks++;
        assert (obs === req) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, req);
        end
    endtask

    task automatic check_all();
        chk("vec0",  vec0, evec[0]);
        chk("vld0",  256'(vv0), 256'(evv[0]));
        chk("cnt0",  256'(dc0), 256'(mcnt[0]));
        chk("busy0", 256'(busy0), 256'(ebusy[0]));
        chk("vec1",  256'(vec1), {128'b0, evec[1][127:0]});
        chk("vld1",  256'(vv1), 256'(evv[1]));
        chk("cnt1",  256'(dc1), 256'(mcnt[1]));
        chk("busy1", 256'(busy1), 256'(ebusy[1]));
    endtask

    task automatic step(input logic r, input logic t, input logic [33:0] p);
        @(negedge clk);
        rst  = r;
        tick = t;
        pkt  = p;
        model_cycle(r, t, p);
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        core_id = 2'd1;
        rst     = 1'b1;
        tick    = 1'b0;
        pkt     = '0;

        // Reset and quiet period.
        step(1'b1, 1'b0, '0);
        step(1'b1, 1'b1, mk(1'b1, 2'd1, 4'd1, 8'd9));
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, '0);
        chk("reset_vec0", vec0, '0);
        chk("reset_busy0", 256'(busy0), '0);
        chk("reset_cnt0", 256'(dc0), '0);

        // Delay-3 spike seen on the third tick only.
        step(1'b0, 1'b0, mk(1'b1, 2'd1, 4'd3, 8'd5));
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, '0);
        chk("d3_tick1", vec0, '0);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, '0);
        chk("d3_tick2", vec0, '0);
        step(1'b0, 1'b0, '0);
        step(1'b0, 1'b1, '0);
        chk("d3_tick3", vec0, bit_at(5));
        chk("d3_valid", 256'(vv0), 256'(1));
        step(1'b0, 1'b0, '0);
        chk("d3_busy", 256'(busy0), '0);
        chk("d3_novalid", 256'(vv0), '0);

        // Same-cycle tick and d=1 packet bypasses the slot.
        step(1'b0, 1'b1, mk(1'b1, 2'd1, 4'd1, 8'd200));
        chk("bypass_vec", vec0, bit_at(200));
        chk("bypass_busy", 256'(busy0), '0);
        step(1'b0, 1'b1, '0);
        chk("bypass_next", vec0, '0);

        // Drops and counter saturation on the narrow-counter instance.
        step(1'b1, 1'b0, '0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, mk(1'b1, 2'd2, 4'd5, 8'd10));
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, mk(1'b1, 2'd1, 4'd5, 8'd255));
        chk("drop6_cnt1", 256'(dc1), 256'(6));
        chk("drop6_cnt0", 256'(dc0), 256'(3));
        chk("drop6_busy1", 256'(busy1), '0);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b0, mk(1'b1, 2'd3, 4'd2, 8'd1));
        chk("drop14_cnt1", 256'(dc1), 256'(14));
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, mk(1'b1, 2'd0, 4'd2, 8'd1));
        chk("sat_cnt1", 256'(dc1), 256'(15));
        chk("sat_cnt0", 256'(dc0), 256'(13));
        step(1'b0, 1'b0, mk(1'b0, 2'd0, 4'd2, 8'd1));
        chk("invalid_nocount", 256'(dc0), 256'(13));

        // Ring wrap: a d=15 spike on every tick lands 14 ticks after its own tick.
        step(1'b1, 1'b0, '0);
        for (int j = 0; j < 33; j++) begin
            if (j < 17) step(1'b0, 1'b1, mk(1'b1, 2'd1, 4'd15, 8'(j)));
            else        step(1'b0, 1'b1, '0);
            if (j >= 14 && j <= 30) chk("wrap_vec", vec0, bit_at(j - 14));
            else                    chk("wrap_vec", vec0, '0);
        end
        chk("wrap_busy", 256'(busy0), '0);

        // d=0 acts as d=1, both with and without a simultaneous tick.
        step(1'b0, 1'b1, mk(1'b1, 2'd1, 4'd0, 8'd77));
        chk("d0_bypass", vec0, bit_at(77));
        step(1'b0, 1'b0, mk(1'b1, 2'd1, 4'd0, 8'd78));
        step(1'b0, 1'b1, '0);
        chk("d0_next", vec0, bit_at(78));
        chk("d0_cnt", 256'(dc0), '0);

        // Mid-run reset discards loaded slots.
        for (int i = 2; i < 6; i++) step(1'b0, 1'b0, mk(1'b1, 2'd1, 4'(i), 8'(i * 11)));
        step(1'b0, 1'b0, mk(1'b1, 2'd2, 4'd1, 8'd1));
        chk("load_busy", 256'(busy0), 256'(1));
        step(1'b1, 1'b1, mk(1'b1, 2'd1, 4'd1, 8'd3));
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, '0);
            chk("postrst_vec", vec0, '0);
        end
        chk("postrst_busy", 256'(busy0), '0);
        chk("postrst_cnt", 256'(dc0), '0);

        // Randomized traffic checked every cycle against the model.
        for (int i = 0; i < 800; i++) begin
            logic        r, t, v;
            logic [1:0]  dest;
            logic [3:0]  d;
            logic [7:0]  ax;
            r    = ($urandom_range(149) == 0);
            t    = ($urandom_range(2) == 0);
            v    = ($urandom_range(3) != 0);
            dest = ($urandom_range(4) == 0) ? 2'($urandom) : 2'd1;
            d    = 4'($urandom);
            ax   = ($urandom_range(1) == 0) ? 8'($urandom_range(127)) : 8'($urandom);
            step(r, t, mk(v, dest, d, ax));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
